// File: rtl/adc_pkg.sv
// Shared definitions for the ADC scheduler: FSM state encoding, default
// timing constants and a small sizing helper.
package adc_pkg;

    // Scheduler FSM states, encoded IDLE=0 .. CAPTURE=5.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAKE    = 3'd1,
        SETTLE  = 3'd2,
        START   = 3'd3,
        CONV    = 3'd4,
        CAPTURE = 3'd5
    } state_t;

    // Default ADC timing (in clk cycles).
    localparam int DEFAULT_PU_CYCLES      = 4;
    localparam int DEFAULT_SETTLE_CYCLES  = 2;
    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

    // Largest of three values; used to size the shared phase counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/adc_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational search starting one past the last
// winner, plus the registered pointer that remembers that winner.
module rr_arbiter
    import adc_pkg::*;
#(
    parameter int NUM_CH = 3,
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] mask,
    input  logic              en,
    output logic [NUM_CH-1:0] winner,
    output logic              any
);

    logic [IDX_W-1:0]  pointer_reg;
    logic [IDX_W-1:0]  win_idx;
    logic [NUM_CH-1:0] eligible;

    // A masked requester is invisible to this arbitration round.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_elig
            assign eligible[gi] = req[gi] & ~mask[gi];
        end
    endgenerate

    // Search pointer+1, pointer+2, ... modulo NUM_CH; first eligible wins.
    always_comb begin
        winner  = '0;
        any     = 1'b0;
        win_idx = pointer_reg;
        for (int k = 1; k <= NUM_CH; k++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!any && (i == ((int'(pointer_reg) + k) % NUM_CH)) && eligible[i]) begin
                    any       = 1'b1;
                    winner[i] = 1'b1;
                    win_idx   = IDX_W'(i);
                end
            end
        end
    end

    // Pointer starts at the last channel so channel 0 has first priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pointer_reg <= IDX_W'(NUM_CH - 1);
        end else if (en && any) begin
            pointer_reg <= win_idx;
        end
    end

endmodule

// File: rtl/adc_scheduler.sv
// Shares one ADC among NUM_CH requesters: wakes/settles the ADC, pulses soc,
// waits for eoc (with timeout), captures the data and returns it with a
// one-cycle done pulse to the granted requester. All outputs are registered
// and reflect the current state (they are loaded from the next-state values).
module adc_scheduler
    import adc_pkg::*;
#(
    parameter int NUM_CH         = 3,
    parameter int DATA_W         = 8,
    parameter int PU_CYCLES      = DEFAULT_PU_CYCLES,      // must be >= 1
    parameter int SETTLE_CYCLES  = DEFAULT_SETTLE_CYCLES,  // must be >= 1
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES  // must be >= 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    output logic [NUM_CH-1:0] grant,
    output logic [NUM_CH-1:0] done,
    output logic              err,
    output logic [DATA_W-1:0] result,
    output logic [NUM_CH-1:0] sel,
    output logic              soc,
    output logic              pd,
    input  logic              eoc,
    input  logic [DATA_W-1:0] adc_data
);

    // One counter serves WAKE, SETTLE and CONV; sized so it never wraps.
    localparam int CNT_W = $clog2(max3(PU_CYCLES, SETTLE_CYCLES, TIMEOUT_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] PU_LAST      = CNT_W'(PU_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [NUM_CH-1:0] grant_reg, grant_next;
    logic [NUM_CH-1:0] done_reg, done_next;
    logic              err_reg, err_next;
    logic [DATA_W-1:0] result_reg, result_next;
    logic              soc_reg;
    logic              pd_reg;

    logic [NUM_CH-1:0] arb_mask;
    logic [NUM_CH-1:0] arb_winner;
    logic              arb_any;
    logic              arb_en;

    // The channel just served is excluded while deciding what follows it.
    assign arb_mask = (state_reg == CAPTURE) ? grant_reg : '0;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .mask   (arb_mask),
        .en     (arb_en),
        .winner (arb_winner),
        .any    (arb_any)
    );

    // Next-state, counter, grant and capture decisions.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        grant_next  = grant_reg;
        done_next   = '0;
        err_next    = 1'b0;
        result_next = result_reg;
        arb_en      = 1'b0;
        unique case (state_reg)
            IDLE: begin
                grant_next = '0;
                if (arb_any) begin
                    state_next = WAKE;
                    grant_next = arb_winner;
                    cnt_next   = '0;
                    arb_en     = 1'b1;
                end
            end
            WAKE: begin
                if (cnt_reg == PU_LAST) begin
                    state_next = START;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            SETTLE: begin
                if (cnt_reg == SETTLE_LAST) begin
                    state_next = START;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            START: begin
                state_next = CONV;
                cnt_next   = '0;
            end
            CONV: begin
                // eoc takes precedence over a timeout in the same cycle.
                if (eoc) begin
                    state_next  = CAPTURE;
                    done_next   = grant_reg;
                    result_next = adc_data;
                end else if (cnt_reg == TIMEOUT_LAST) begin
                    state_next  = CAPTURE;
                    done_next   = grant_reg;
                    err_next    = 1'b1;
                    result_next = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            CAPTURE: begin
                cnt_next = '0;
                if (!arb_any) begin
                    state_next = IDLE;
                    grant_next = '0;
                end else begin
                    arb_en     = 1'b1;
                    grant_next = arb_winner;
                    state_next = (arb_winner == grant_reg) ? START : SETTLE;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    // FSM state, phase counter and the served channel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            grant_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            grant_reg <= grant_next;
        end
    end

    // Registered ADC-side and client-side outputs, aligned with the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done_reg   <= '0;
            err_reg    <= 1'b0;
            result_reg <= '0;
            soc_reg    <= 1'b0;
            pd_reg     <= 1'b1;
        end else begin
            done_reg   <= done_next;
            err_reg    <= err_next;
            result_reg <= result_next;
            soc_reg    <= (state_next == START);
            pd_reg     <= (state_next == IDLE);
        end
    end

    assign grant  = grant_reg;
    assign sel    = grant_reg;
    assign done   = done_reg;
    assign err    = err_reg;
    assign result = result_reg;
    assign soc    = soc_reg;
    assign pd     = pd_reg;

endmodule

// File: tb/tb_adc_scheduler.sv
// Self-checking bench for adc_scheduler. Each scenario fills per-cycle
// stimulus tables (eoc, adc_data, reset), then a transaction-level model
// derives the request waveform and the expected outputs for every cycle by
// walking grants in round-robin order and placing soc/done by arithmetic.
module tb_adc_scheduler;

    localparam int PU   = 4;
    localparam int ST   = 2;
    localparam int TO   = 255;
    localparam int MAXN = 1600;
    localparam int BIG  = 1 << 30;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] req;
    logic [0:0] req1;
    logic       eoc;
    logic [7:0] adc_data;

    logic [2:0] grant, done, sel;
    logic       err, soc, pd;
    logic [7:0] result;
    logic [0:0] grant1, done1, sel1;
    logic       err1, soc1, pd1;
    logic [7:0] result1;

    always #5 clk = ~clk;

    adc_scheduler #(.NUM_CH(3), .DATA_W(8), .PU_CYCLES(PU), .SETTLE_CYCLES(ST), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .grant(grant), .done(done), .err(err),
        .result(result), .sel(sel), .soc(soc), .pd(pd), .eoc(eoc), .adc_data(adc_data));

    adc_scheduler #(.NUM_CH(1), .DATA_W(8), .PU_CYCLES(PU), .SETTLE_CYCLES(ST), .TIMEOUT_CYCLES(TO)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .grant(grant1), .done(done1), .err(err1),
        .result(result1), .sel(sel1), .soc(soc1), .pd(pd1), .eoc(eoc), .adc_data(adc_data));

    int total = 0;
    int bad   = 0;

    int n_cyc, nch, gap_max, drop_pct, fix_drop_ch, fix_drop_cyc;
    int which, cyc, scen;
    bit active = 1'b0;
    int arrival [3];

    logic [2:0] req_tab  [MAXN];
    bit         eoc_tab  [MAXN];
    logic [7:0] data_tab [MAXN];
    bit         rst_tab  [MAXN];

    logic [2:0] e_grant [MAXN];
    logic [2:0] e_done  [MAXN];
    bit         e_pd    [MAXN];
    bit         e_soc   [MAXN];
    bit         e_err   [MAXN];
    logic [7:0] e_res   [MAXN];

    function automatic void put(int c, int g, bit p, bit s, int dn, bit er, logic [7:0] r);
        if (c < n_cyc) begin
            e_grant[c] = 3'(g);
            e_pd[c]    = p;
            e_soc[c]   = s;
            e_done[c]  = 3'(dn);
            e_err[c]   = er;
            e_res[c]   = r;
        end
    endfunction

    // Round robin over requesters whose request is up at cycle t.
    function automatic int rr_pick(int t, int ptr, int mask);
        for (int k = 1; k <= nch; k++) begin
            int i;
            i = (ptr + k) % nch;
            if (i != mask && arrival[i] <= t) return i;
        end
        return -1;
    endfunction

    task automatic setup(int n, int nch_);
        n_cyc = n; nch = nch_; gap_max = -1; drop_pct = 0; fix_drop_ch = -1; fix_drop_cyc = 0;
        for (int i = 0; i < 3; i++) arrival[i] = BIG;
        for (int c = 0; c < MAXN; c++) begin
            req_tab[c] = '0; eoc_tab[c] = 1'b0; data_tab[c] = '0; rst_tab[c] = 1'b0;
        end
    endtask

    task automatic gen_random(int n, int nch_, int eoc_pct, int rst_pm);
        setup(n, nch_);
        gap_max = 10; drop_pct = 25;
        for (int c = 0; c < n; c++) begin
            eoc_tab[c]  = ($urandom_range(99) < 32'(eoc_pct));
            data_tab[c] = 8'($urandom);
            rst_tab[c]  = (c > 20) && ($urandom_range(999) < 32'(rst_pm));
        end
        for (int i = 0; i < nch_; i++) arrival[i] = int'($urandom_range(10));
    endtask

    // Walk the transactions: prep (PU or SETTLE) cycles, soc, conversion
    // window of up to TO cycles, then the done cycle and the next arbitration.
    task automatic build_model();
        int t, ptr, w, g, wprep, s, e, d, r, last, hold_end, tarb;
        bit found;
        logic [7:0] res, newres;
        t = 0; ptr = nch - 1; res = 8'h00; w = -1; wprep = PU;
        while (t < n_cyc) begin
            if (w < 0) begin
                put(t, 0, 1'b1, 1'b0, 0, 1'b0, res);
                if (rst_tab[t]) begin ptr = nch - 1; res = 8'h00; t++; continue; end
                w = rr_pick(t, ptr, -1);
                if (w < 0) begin t++; continue; end
                wprep = PU;
            end
            g = w; ptr = w; tarb = t;
            s = t + wprep + 1; e = s + TO; found = 1'b0;
            for (int c = s + 1; c <= s + TO; c++) begin
                if (c < n_cyc && eoc_tab[c]) begin e = c; found = 1'b1; break; end
            end
            d = e + 1;
            newres = found ? data_tab[e] : 8'h00;
            r = -1;
            for (int c = t + 1; c <= d && c < n_cyc; c++) begin
                if (rst_tab[c]) begin r = c; break; end
            end
            last = (r >= 0) ? r : d;
            for (int c = t + 1; c <= last; c++)
                put(c, 1 << g, 1'b0, c == s, (c == d) ? (1 << g) : 0, (c == d) && !found, (c == d) ? newres : res);
            w = -1;
            if (r >= 0 && r < d) begin ptr = nch - 1; res = 8'h00; t = r + 1; continue; end
            res = newres;
            hold_end = d;
            if (g == fix_drop_ch) hold_end = fix_drop_cyc;
            else if ($urandom_range(99) < 32'(drop_pct)) hold_end = int'($urandom_range(d, tarb));
            for (int c = arrival[g]; c <= hold_end && c < n_cyc; c++) req_tab[c][g] = 1'b1;
            arrival[g] = (gap_max < 0) ? BIG : d + 1 + int'($urandom_range(gap_max, 0));
            if (r == d) begin ptr = nch - 1; res = 8'h00; t = d + 1; continue; end
            w = rr_pick(d, ptr, g);
            if (w < 0) begin t = d + 1; continue; end
            wprep = (w == g) ? 0 : ST;
            t = d;
        end
        for (int i = 0; i < nch; i++)
            for (int c = arrival[i]; c < n_cyc; c++) req_tab[c][i] = 1'b1;
    endtask

    task automatic pin(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL pin %s: model gives %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic run_scen(input int which_);
        which = which_;
        scen++;
        rst_n = 1'b0; req = '0; req1 = '0; eoc = 1'b0; adc_data = '0;
        repeat (2) @(posedge clk);
        #1;
        active = 1'b1;
        for (int c = 0; c < n_cyc; c++) begin
            cyc      = c;
            rst_n    = !rst_tab[c];
            req      = (which == 0) ? req_tab[c] : 3'b000;
            req1     = (which == 0) ? 1'b0 : req_tab[c][0];
            eoc      = eoc_tab[c];
            adc_data = data_tab[c];
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        active = 1'b0;
    endtask

    // Single compare process: every cycle of a scenario, all outputs.
    logic [2:0] a_grant, a_done, a_sel;
    logic       a_err, a_soc, a_pd;
    logic [7:0] a_res;
    initial begin
        forever begin
            @(negedge clk);
            if (active) begin
                if (which == 0) begin
                    a_grant = grant; a_done = done; a_sel = sel;
                    a_err = err; a_soc = soc; a_pd = pd; a_res = result;
                end else begin
                    a_grant = {2'b00, grant1}; a_done = {2'b00, done1}; a_sel = {2'b00, sel1};
                    a_err = err1; a_soc = soc1; a_pd = pd1; a_res = result1;
                end
                total++;
                if ({a_grant, a_sel, a_done, a_err, a_soc, a_pd, a_res} !==
                    {e_grant[cyc], e_grant[cyc], e_done[cyc], e_err[cyc], e_soc[cyc], e_pd[cyc], e_res[cyc]}) begin
                    bad++;
                    $display("FAIL outputs scen=%0d cyc=%0d got grant=%b sel=%b done=%b err=%b soc=%b pd=%b result=%h want grant=%b sel=%b done=%b err=%b soc=%b pd=%b result=%h",
                             scen, cyc, a_grant, a_sel, a_done, a_err, a_soc, a_pd, a_res,
                             e_grant[cyc], e_grant[cyc], e_done[cyc], e_err[cyc], e_soc[cyc], e_pd[cyc], e_res[cyc]);
                end
                if (e_done[cyc] != 3'b000)
                    $display("txn scen=%0d cyc=%0d done=%b result=%h err=%b", scen, cyc, e_done[cyc], e_res[cyc], e_err[cyc]);
            end
        end
    end

    initial begin
        scen = 0;
        which = 0;
        cyc = 0;

        // Single request, eoc on cycle 9 with A5.
        setup(30, 3);
        arrival[0] = 0; eoc_tab[9] = 1'b1; data_tab[9] = 8'hA5;
        build_model();
        pin("basic grant@1", int'(e_grant[1]), 1);
        pin("basic soc@4", int'(e_soc[4]), 0);
        pin("basic soc@5", int'(e_soc[5]), 1);
        pin("basic done@10", int'(e_done[10]), 1);
        pin("basic result@10", int'(e_res[10]), 8'hA5);
        pin("basic pd@11", int'(e_pd[11]), 1);
        run_scen(0);

        // All three held, eoc permanently high (also during WAKE/SETTLE).
        setup(40, 3);
        arrival[0] = 0; arrival[1] = 0; arrival[2] = 0; gap_max = 0;
        for (int c = 0; c < 40; c++) begin eoc_tab[c] = 1'b1; data_tab[c] = 8'(c * 7); end
        build_model();
        pin("rr done@7", int'(e_done[7]), 1);
        pin("rr done@12", int'(e_done[12]), 2);
        pin("rr done@17", int'(e_done[17]), 4);
        pin("rr grant@18", int'(e_grant[18]), 1);
        pin("rr soc@20", int'(e_soc[20]), 1);
        run_scen(0);

        // eoc never arrives: timeout.
        setup(270, 3);
        arrival[0] = 0;
        build_model();
        pin("timeout done@260", int'(e_done[260]), 0);
        pin("timeout done@261", int'(e_done[261]), 1);
        pin("timeout err@261", int'(e_err[261]), 1);
        run_scen(0);

        // eoc on the last wait cycle wins; eoc in WAKE and CAPTURE ignored.
        setup(270, 3);
        arrival[0] = 0; eoc_tab[2] = 1'b1; eoc_tab[3] = 1'b1; data_tab[3] = 8'h11;
        eoc_tab[260] = 1'b1; data_tab[260] = 8'h3C; eoc_tab[261] = 1'b1; data_tab[261] = 8'h77;
        build_model();
        pin("lastwait err@261", int'(e_err[261]), 0);
        pin("lastwait result@261", int'(e_res[261]), 8'h3C);
        run_scen(0);

        // req[1] dropped during CONV still gets its done.
        setup(30, 3);
        arrival[1] = 0; fix_drop_ch = 1; fix_drop_cyc = 8;
        eoc_tab[3] = 1'b1; eoc_tab[11] = 1'b1; data_tab[11] = 8'h5A;
        build_model();
        pin("drop done@12", int'(e_done[12]), 2);
        run_scen(0);

        // One-cycle reset during CONV, req[2] held throughout.
        setup(40, 3);
        arrival[2] = 0; rst_tab[12] = 1'b1;
        build_model();
        pin("reset pd@13", int'(e_pd[13]), 1);
        pin("reset grant@14", int'(e_grant[14]), 4);
        pin("reset soc@18", int'(e_soc[18]), 1);
        run_scen(0);

        // Single channel, req held: back through IDLE between conversions.
        setup(40, 1);
        arrival[0] = 0; gap_max = 0;
        for (int c = 0; c < 40; c++) begin eoc_tab[c] = 1'b1; data_tab[c] = 8'(c + 3); end
        build_model();
        pin("nch1 pd@8", int'(e_pd[8]), 1);
        pin("nch1 grant@9", int'(e_grant[9]), 1);
        pin("nch1 soc@13", int'(e_soc[13]), 1);
        run_scen(1);

        // Randomized traffic.
        gen_random(800, 3, 20, 3);
        build_model();
        run_scen(0);
        gen_random(800, 3, 35, 0);
        build_model();
        run_scen(0);
        gen_random(1500, 3, 1, 2);
        build_model();
        run_scen(0);
        gen_random(400, 1, 20, 3);
        build_model();
        run_scen(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
